// File: rtl/cl_sdp_axi_mem_slave_if.sv
// AXI4 bus bundle between an SDP shield master and the memory-backed slave.
// Carries AW/W/B/AR/R channels; burst type, size, lock and cache are implied (INCR, full width).
interface cl_sdp_axi_mem_slave_if #(
   parameter int unsigned C_ADDR_WIDTH = 64,
   parameter int unsigned C_DATA_WIDTH = 64,
   parameter int unsigned C_ID_WIDTH   = 6
);
   logic [C_ID_WIDTH-1:0]     awid;
   logic [C_ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]                awlen;
   logic                      awvalid;
   logic                      awready;
   logic [C_DATA_WIDTH-1:0]   wdata;
   logic [C_DATA_WIDTH/8-1:0] wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [C_ID_WIDTH-1:0]     bid;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [C_ID_WIDTH-1:0]     arid;
   logic [C_ADDR_WIDTH-1:0]   araddr;
   logic [7:0]                arlen;
   logic                      arvalid;
   logic                      arready;
   logic [C_ID_WIDTH-1:0]     rid;
   logic [C_DATA_WIDTH-1:0]   rdata;
   logic [1:0]                rresp;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output arid, araddr, arlen, arvalid, rready,
      input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  arid, araddr, arlen, arvalid, rready,
      output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/cl_sdp_axi_mem_slave.sv
// AXI4 INCR-only slave over an internal word memory; independent read and write FSMs.
// Define CL_SDP_AXI_MEM_SLAVE_RANGE_CHECK_EN to flag/drop beats beyond the memory size.
module cl_sdp_axi_mem_slave #(
   parameter int unsigned C_ADDR_WIDTH = 64,
   parameter int unsigned C_DATA_WIDTH = 64,
   parameter int unsigned C_ID_WIDTH   = 6,
   parameter int unsigned C_MEM_DEPTH  = 1024
) (
   input logic                   aclk,
   input logic                   areset,
   cl_sdp_axi_mem_slave_if.slave s_axi
);
   localparam int unsigned Bytes   = C_DATA_WIDTH / 8;
   localparam int unsigned AddrLsb = $clog2(Bytes);
   localparam int unsigned IdxW    = $clog2(C_MEM_DEPTH);
   localparam logic [C_ADDR_WIDTH-1:0] BeatBytes = C_ADDR_WIDTH'(Bytes);

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic [0:0] {RIdle, RData} r_state_e;

   logic [C_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH];

   w_state_e                w_state_q;
   logic                    awready_q, wready_q, bvalid_q, werr_q;
   logic [C_ID_WIDTH-1:0]   bid_q;
   logic [1:0]              bresp_q;
   logic [C_ADDR_WIDTH-1:0] waddr_q;
   logic [7:0]              wlen_q, wcnt_q;

   r_state_e                r_state_q;
   logic                    arready_q, rvalid_q, rlast_q;
   logic [C_ID_WIDTH-1:0]   rid_q;
   logic [1:0]              rresp_q;
   logic [C_DATA_WIDTH-1:0] rdata_q;
   logic [C_ADDR_WIDTH-1:0] raddr_q;
   logic [7:0]              rlen_q, rcnt_q;

   logic                    w_fire, w_is_last, w_err_d, w_oor, r_oor;
   logic [IdxW-1:0]         w_idx, r_load_idx;
   logic [C_ADDR_WIDTH-1:0] r_load_addr;
   logic [C_DATA_WIDTH-1:0] r_load_word;
   logic [1:0]              r_load_resp;

   assign w_fire    = s_axi.wvalid && wready_q;
   assign w_is_last = (wcnt_q == wlen_q);
   assign w_idx     = waddr_q[AddrLsb +: IdxW];
   // wlast must coincide with the final counted beat; any early or missing wlast is an error
   assign w_err_d   = werr_q | w_oor | (s_axi.wlast != w_is_last);

   // The first beat is fetched straight off the AR bus so rvalid follows the handshake by one cycle
   assign r_load_addr = (r_state_q == RIdle) ? s_axi.araddr : raddr_q;
   assign r_load_idx  = r_load_addr[AddrLsb +: IdxW];
   assign r_load_word = r_oor ? '0 : mem_q[r_load_idx];
   assign r_load_resp = r_oor ? 2'b10 : 2'b00;

`ifdef CL_SDP_AXI_MEM_SLAVE_RANGE_CHECK_EN
   localparam logic [C_ADDR_WIDTH-1:0] MemBytes = C_ADDR_WIDTH'(C_MEM_DEPTH * Bytes);
   assign w_oor = (waddr_q >= MemBytes);
   assign r_oor = (r_load_addr >= MemBytes);
`else
   logic unused_addr_bits;
   assign w_oor = 1'b0;
   assign r_oor = 1'b0;
   assign unused_addr_bits = ^{waddr_q, r_load_addr};
`endif

   always_ff @(posedge aclk) begin
      if (w_fire && !w_oor) begin
         for (int b = 0; b < Bytes; b++) begin
            if (s_axi.wstrb[b]) mem_q[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q <= WIdle;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         werr_q    <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= 2'b00;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         unique case (w_state_q)
            WIdle: begin
               awready_q <= 1'b1;
               if (s_axi.awvalid && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  bid_q     <= s_axi.awid;
                  waddr_q   <= s_axi.awaddr;
                  wlen_q    <= s_axi.awlen;
                  wcnt_q    <= '0;
                  werr_q    <= 1'b0;
                  w_state_q <= WData;
               end
            end
            WData: begin
               if (w_fire) begin
                  waddr_q <= waddr_q + BeatBytes;
                  wcnt_q  <= wcnt_q + 8'd1;
                  werr_q  <= w_err_d;
                  if (w_is_last) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= w_err_d ? 2'b10 : 2'b00;
                     w_state_q <= WResp;
                  end
               end
            end
            WResp: begin
               if (s_axi.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= WIdle;
               end
            end
            default: w_state_q <= WIdle;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state_q <= RIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else begin
         unique case (r_state_q)
            RIdle: begin
               arready_q <= 1'b1;
               if (s_axi.arvalid && arready_q) begin
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rid_q     <= s_axi.arid;
                  rlen_q    <= s_axi.arlen;
                  rdata_q   <= r_load_word;
                  rresp_q   <= r_load_resp;
                  rlast_q   <= (s_axi.arlen == 8'd0);
                  raddr_q   <= s_axi.araddr + BeatBytes;
                  rcnt_q    <= 8'd1;
                  r_state_q <= RData;
               end
            end
            RData: begin
               if (s_axi.rready) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state_q <= RIdle;
                  end else begin
                     rdata_q <= r_load_word;
                     rresp_q <= r_load_resp;
                     rlast_q <= (rcnt_q == rlen_q);
                     raddr_q <= raddr_q + BeatBytes;
                     rcnt_q  <= rcnt_q + 8'd1;
                  end
               end
            end
            default: r_state_q <= RIdle;
         endcase
      end
   end

   assign s_axi.awready = awready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = arready_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rlast   = rlast_q;
endmodule

// File: tb/tb_cl_sdp_axi_mem_slave.sv
// Directed bench for cl_sdp_axi_mem_slave: write/read bursts, strobes, backpressure,
// wlast mismatch, index wrap (or range errors with CL_SDP_AXI_MEM_SLAVE_RANGE_CHECK_EN), reset.
module tb_cl_sdp_axi_mem_slave;
   logic aclk;
   logic areset;

   cl_sdp_axi_mem_slave_if #(.C_ADDR_WIDTH(64), .C_DATA_WIDTH(64), .C_ID_WIDTH(6)) s_axi ();

   cl_sdp_axi_mem_slave #(
      .C_ADDR_WIDTH(64),
      .C_DATA_WIDTH(64),
      .C_ID_WIDTH  (6),
      .C_MEM_DEPTH (1024)
   ) u_dut (
      .aclk  (aclk),
      .areset(areset),
      .s_axi (s_axi)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [63:0] wbuf      [16];
   logic [63:0] rbuf      [16];
   logic        rlastbuf  [16];
   logic [1:0]  rrespbuf  [16];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [5:0] id,
                            input logic [7:0] strb, input int last_beat, input bit hold_b,
                            output logic [1:0] resp, output logic [5:0] bid);
      int n;
      s_axi.awaddr  = addr;
      s_axi.awlen   = len;
      s_axi.awid    = id;
      s_axi.awvalid = 1'b1;
      n = 0;
      while (!s_axi.awready && n < 50) begin tick(); n++; end
      if (!s_axi.awready) chk("aw_timeout", {63'd0, s_axi.awready}, 64'd1);
      tick();
      s_axi.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         s_axi.wdata  = wbuf[i];
         s_axi.wstrb  = strb;
         s_axi.wlast  = (i == last_beat);
         s_axi.wvalid = 1'b1;
         n = 0;
         while (!s_axi.wready && n < 50) begin tick(); n++; end
         if (!s_axi.wready) chk("w_timeout", {63'd0, s_axi.wready}, 64'd1);
         tick();
      end
      s_axi.wvalid = 1'b0;
      s_axi.wlast  = 1'b0;
      s_axi.bready = !hold_b;
      n = 0;
      while (!s_axi.bvalid && n < 50) begin tick(); n++; end
      if (!s_axi.bvalid) chk("b_timeout", {63'd0, s_axi.bvalid}, 64'd1);
      if (hold_b) begin
         for (int c = 0; c < 5; c++) begin
            chk("b_hold_bvalid", {63'd0, s_axi.bvalid}, 64'd1);
            chk("b_hold_awready", {63'd0, s_axi.awready}, 64'd0);
            tick();
         end
         s_axi.bready = 1'b1;
      end
      resp = s_axi.bresp;
      bid  = s_axi.bid;
      tick();
      s_axi.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [5:0] id,
                           input bit toggle);
      int n, nb, cyc;
      bit stalled;
      logic [63:0] held;
      logic        held_last;
      s_axi.araddr  = addr;
      s_axi.arlen   = len;
      s_axi.arid    = id;
      s_axi.arvalid = 1'b1;
      s_axi.rready  = 1'b1;
      n = 0;
      while (!s_axi.arready && n < 50) begin tick(); n++; end
      if (!s_axi.arready) chk("ar_timeout", {63'd0, s_axi.arready}, 64'd1);
      tick();
      s_axi.arvalid = 1'b0;
      chk("r_first_valid", {63'd0, s_axi.rvalid}, 64'd1);
      nb = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      held_last = 1'b0;
      while (nb <= int'(len) && cyc < 200) begin
         if (stalled) begin
            chk("r_stall_data", s_axi.rdata, held);
            chk("r_stall_last", {63'd0, s_axi.rlast}, {63'd0, held_last});
         end
         stalled = s_axi.rvalid && !s_axi.rready;
         held = s_axi.rdata;
         held_last = s_axi.rlast;
         if (s_axi.rvalid && s_axi.rready) begin
            rbuf[nb]     = s_axi.rdata;
            rlastbuf[nb] = s_axi.rlast;
            rrespbuf[nb] = s_axi.rresp;
            chk("r_id", {58'd0, s_axi.rid}, {58'd0, id});
            nb++;
         end
         tick();
         cyc++;
         if (toggle) s_axi.rready = ~s_axi.rready;
      end
      s_axi.rready = 1'b0;
      if (nb <= int'(len)) chk("r_timeout", 64'(nb), 64'(len) + 64'd1);
      if (!toggle) chk("r_cycles", 64'(cyc), 64'(len) + 64'd1);
      chk("r_done_rvalid", {63'd0, s_axi.rvalid}, 64'd0);
   endtask

   logic [1:0] resp;
   logic [5:0] bid;

   initial begin
      areset = 1'b1;
      s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awvalid = 1'b0;
      s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
      s_axi.bready = 1'b0;
      s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arvalid = 1'b0;
      s_axi.rready = 1'b0;

      // Reset state
      #12;
      chk("rst_awready", {63'd0, s_axi.awready}, 64'd0);
      chk("rst_arready", {63'd0, s_axi.arready}, 64'd0);
      chk("rst_bvalid",  {63'd0, s_axi.bvalid},  64'd0);
      chk("rst_rvalid",  {63'd0, s_axi.rvalid},  64'd0);
      chk("rst_rdata",   s_axi.rdata,            64'd0);
      @(negedge aclk);
      areset = 1'b0;
      tick();
      chk("idle_awready", {63'd0, s_axi.awready}, 64'd1);
      chk("idle_arready", {63'd0, s_axi.arready}, 64'd1);

      // Basic write then read
      for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
      axi_write(64'h40, 8'd3, 6'd5, 8'hFF, 3, 1'b0, resp, bid);
      chk("wr_bresp", {62'd0, resp}, 64'd0);
      chk("wr_bid", {58'd0, bid}, 64'd5);
      axi_read(64'h40, 8'd3, 6'd9, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("rd_data", rbuf[i], 64'(i + 1));
         chk("rd_last", {63'd0, rlastbuf[i]}, (i == 3) ? 64'd1 : 64'd0);
         chk("rd_resp", {62'd0, rrespbuf[i]}, 64'd0);
      end

      // Byte strobes
      wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
      axi_write(64'h100, 8'd0, 6'd1, 8'hFF, 0, 1'b0, resp, bid);
      wbuf[0] = 64'h0;
      axi_write(64'h100, 8'd0, 6'd1, 8'h0F, 0, 1'b0, resp, bid);
      axi_read(64'h100, 8'd0, 6'd2, 1'b0);
      chk("strb_data", rbuf[0], 64'hFFFF_FFFF_0000_0000);
      chk("strb_last", {63'd0, rlastbuf[0]}, 64'd1);

      // Read backpressure: rready toggles every cycle
      for (int i = 0; i < 8; i++) wbuf[i] = 64'h100 + 64'(i);
      axi_write(64'h200, 8'd7, 6'd7, 8'hFF, 7, 1'b0, resp, bid);
      axi_read(64'h200, 8'd7, 6'd11, 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk("bp_data", rbuf[i], 64'h100 + 64'(i));
         chk("bp_last", {63'd0, rlastbuf[i]}, (i == 7) ? 64'd1 : 64'd0);
      end

      // Write response backpressure
      wbuf[0] = 64'hDEAD_BEEF_0000_0001;
      axi_write(64'h300, 8'd0, 6'd33, 8'hFF, 0, 1'b1, resp, bid);
      chk("bhold_bresp", {62'd0, resp}, 64'd0);
      chk("bhold_bid", {58'd0, bid}, 64'd33);

      // wlast on the second beat of four
      for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
      axi_write(64'h400, 8'd3, 6'd4, 8'hFF, 1, 1'b0, resp, bid);
      chk("wlast_bresp", {62'd0, resp}, 64'd2);
      axi_read(64'h400, 8'd3, 6'd4, 1'b0);
      for (int i = 0; i < 4; i++) chk("wlast_data", rbuf[i], 64'hA0 + 64'(i));

      // Burst starting at the last word
      wbuf[0] = 64'h1111_AAAA;
      wbuf[1] = 64'h2222_BBBB;
      axi_write(64'h1FF8, 8'd1, 6'd6, 8'hFF, 1, 1'b0, resp, bid);
      axi_read(64'h1FF8, 8'd1, 6'd6, 1'b0);
      chk("wrap_beat0", rbuf[0], 64'h1111_AAAA);
      chk("wrap_resp0", {62'd0, rrespbuf[0]}, 64'd0);
`ifdef CL_SDP_AXI_MEM_SLAVE_RANGE_CHECK_EN
      chk("range_bresp", {62'd0, resp}, 64'd2);
      chk("range_beat1", rbuf[1], 64'd0);
      chk("range_resp1", {62'd0, rrespbuf[1]}, 64'd2);
`else
      chk("wrap_bresp", {62'd0, resp}, 64'd0);
      chk("wrap_beat1", rbuf[1], 64'h2222_BBBB);
      chk("wrap_resp1", {62'd0, rrespbuf[1]}, 64'd0);
      axi_read(64'h0, 8'd0, 6'd6, 1'b0);
      chk("wrap_word0", rbuf[0], 64'h2222_BBBB);
`endif

      // Reset during beat 2 of an 8-beat read
      s_axi.araddr  = 64'h200;
      s_axi.arlen   = 8'd7;
      s_axi.arid    = 6'd3;
      s_axi.arvalid = 1'b1;
      s_axi.rready  = 1'b1;
      chk("mid_arready", {63'd0, s_axi.arready}, 64'd1);
      tick();
      s_axi.arvalid = 1'b0;
      tick();
      chk("mid_rvalid_pre", {63'd0, s_axi.rvalid}, 64'd1);
      chk("mid_beat2", s_axi.rdata, 64'h101);
      areset = 1'b1;
      #1;
      chk("mid_rvalid_rst", {63'd0, s_axi.rvalid}, 64'd0);
      chk("mid_rlast_rst", {63'd0, s_axi.rlast}, 64'd0);
      chk("mid_arready_rst", {63'd0, s_axi.arready}, 64'd0);
      s_axi.rready = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      tick();
      chk("mid_arready_post", {63'd0, s_axi.arready}, 64'd1);
      axi_read(64'h200, 8'd7, 6'd12, 1'b0);
      for (int i = 0; i < 8; i++) chk("post_rst_data", rbuf[i], 64'h100 + 64'(i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cl_sdp_axi_mem_slave.md
Name: cl_sdp_axi_mem_slave

Overview:
- AXI4 slave (responder) backed by an internal word-addressed memory array.
- Terminates the AXI4 master port of the SDP shield read/write masters, so DMA paths can be simulated and tested in loopback without the DDR controller.
- Independent read and write channel state machines; one outstanding burst per direction; INCR bursts only.

Parameters:
- C_ADDR_WIDTH, 64, AXI address width.
- C_DATA_WIDTH, 64, AXI data width (bytes per beat = C_DATA_WIDTH/8).
- C_ID_WIDTH, 6, AXI ID width.
- C_MEM_DEPTH, 1024, memory words (power of 2); index = addr[$clog2(C_DATA_WIDTH/8) +: $clog2(C_MEM_DEPTH)].

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axi_awid  in  C_ID_WIDTH  write ID
- s_axi_awaddr  in  C_ADDR_WIDTH  write byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  C_DATA_WIDTH  write data
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bid  out  C_ID_WIDTH  response ID
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_arid  in  C_ID_WIDTH  read ID
- s_axi_araddr  in  C_ADDR_WIDTH  read byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rid  out  C_ID_WIDTH  read ID
- s_axi_rdata  out  C_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake

Behaviour:
- Reset (async assert): all valid/ready outputs, bid, bresp, rid, rresp, rlast, rdata = 0; both FSMs return to IDLE. Memory contents are not reset. Reset asserted mid-burst abandons the burst with no response.
- awburst/arburst/size/lock/cache are not ported; every burst is INCR, full-width. Word index increments by 1 per beat and wraps modulo C_MEM_DEPTH.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches awid, index and awlen; beat counter cleared; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes selected by wstrb; bytes with strobe 0 are unchanged. On the beat where counter==awlen, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched awid. bresp=OKAY (2'b00), or SLVERR (2'b10) if wlast was not asserted exactly on the final beat. Hold until bready, then go to W_IDLE.
  - The AW handshake and the first W beat cannot occur in the same cycle; wready=0 in W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. AR handshake latches arid, index and arlen; go to R_DATA.
  - R_DATA: rvalid is asserted the cycle after the AR handshake; rdata, rid and rlast are registered. rlast=1 when beat counter==arlen. On an R handshake, the next word is loaded the same edge, so back-to-back beats are issued while rready=1. R handshake with rlast returns to R_IDLE.
  - While rvalid=1 and rready=0, rdata/rid/rlast/rresp stay stable.
  - rresp=OKAY.
- Simultaneous write and read-load of the same word: read is read-before-write, returning the pre-write data.
- Read and write channels are fully concurrent; no ordering between them.

Optional Feature:
- Macro: CL_SDP_AXI_MEM_SLAVE_RANGE_CHECK_EN.
- Defined: any beat whose byte address ≥ C_MEM_DEPTH*(C_DATA_WIDTH/8), computed on the full address without wrap, is out of range.
  - Write beats out of range are dropped and force bresp=SLVERR.
  - Read beats out of range return rdata=0 with rresp=SLVERR for that beat.
  - In-range beats in the same burst behave normally.
- Undefined: upper address bits are ignored, indices wrap, and responses are OKAY, except the wlast-mismatch SLVERR.

Test Plan:
- Write then read: AW addr 0x40, awlen=3, data 1..4, wstrb=0xFF -> bresp=00, bid=awid. AR 0x40, arlen=3 with rready=1 -> rdata 1,2,3,4 on consecutive cycles, rlast on beat 4, first rvalid 1 cycle after AR.
- Byte strobes: preload 0xFFFF_FFFF_FFFF_FFFF, write 0 with wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
- Backpressure: read awlen=7, toggle rready 1/0 each cycle -> rdata stable while stalled; 8 beats in order; single rlast. Hold bready=0 for 5 cycles -> bvalid held, awready=0 throughout.
- wlast mismatch: awlen=3, wlast on beat 2 -> 4 beats accepted, bresp=10.
- Wrap/range: C_MEM_DEPTH=1024, write at word 1023, awlen=1 -> without macro, second beat lands at word 0 and bresp=00; with macro, second beat dropped and bresp=10.
- Reset mid-burst: assert areset during beat 2 of an 8-beat read -> rvalid=0 immediately; after release arready=1, and a new burst reads correctly.
